// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared encodings, FSM states and TMS patterns for the JTAG host
package jtag_host_pkg;

  // Command type encodings
  localparam logic [1:0] CMD_RST = 2'd0;
  localparam logic [1:0] CMD_IR  = 2'd1;
  localparam logic [1:0] CMD_DR  = 2'd2;
  localparam logic [1:0] CMD_NOP = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SHIFT = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // TMS patterns, bit 0 is the first TCK period
  localparam logic [5:0] RST_TMS    = 6'b011111;
  localparam logic [3:0] IR_HDR_TMS = 4'b0011;
  localparam logic [2:0] DR_HDR_TMS = 3'b001;
  localparam logic [1:0] POST_TMS   = 2'b01;

  localparam logic [5:0] RST_LEN    = 6'd6;
  localparam logic [5:0] IR_HDR_LEN = 6'd4;
  localparam logic [5:0] DR_HDR_LEN = 6'd3;
  localparam logic [5:0] POST_LEN   = 6'd2;

  // Header TMS pattern for a command type, zero-extended to 6 bits.
  // A TAP reset is treated as a header-only sequence.
  function automatic logic [5:0] hdr_tms(input logic [1:0] t);
    case (t)
      CMD_IR:  return {2'b00, IR_HDR_TMS};
      CMD_DR:  return {3'b000, DR_HDR_TMS};
      default: return RST_TMS;
    endcase
  endfunction

  // Index of the last header period for a command type
  function automatic logic [5:0] hdr_last(input logic [1:0] t);
    case (t)
      CMD_IR:  return IR_HDR_LEN - 6'd1;
      CMD_DR:  return DR_HDR_LEN - 6'd1;
      default: return RST_LEN - 6'd1;
    endcase
  endfunction

  // cmd_len of 0 encodes a full 32-bit scan
  function automatic logic [5:0] decode_len(input logic [4:0] l);
    return (l == 5'd0) ? 6'd32 : {1'b0, l};
  endfunction

endpackage

// File: rtl/jtag_host_tckgen.sv
// rtl/jtag_host_tckgen.sv - TCK divider with rise/fall strobes, parked low when disabled
module jtag_host_tckgen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap;

  // Count DIV cycles per phase; a disabled divider restarts at the low phase
  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = '0;
    tck_d = 1'b0;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      tck_d = wrap ? ~tck_q : tck_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  // Strobes mark the clk edge that raises or lowers TCK
  assign tck      = tck_q;
  assign rise_stb = wrap & ~tck_q;
  assign fall_stb = wrap & tck_q;

endmodule

// File: rtl/jtag_host_drv.sv
// rtl/jtag_host_drv.sv - JTAG host issuing TAP reset, IR scan and DR scan commands
module jtag_host_drv
  import jtag_host_pkg::*;
#(
  parameter int DIV = 4,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_type,
  input  logic [4:0]    cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          jtag_tck,
  output logic          jtag_tms,
  output logic          jtag_tdi,
  input  logic          jtag_tdo
);

  state_e        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [5:0]    len_q, len_d;
  logic [5:0]    idx_q, idx_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [DW-1:0] rsp_q, rsp_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          finish;
  logic [5:0]    hdr_pat;
  logic          tck_en;
  logic          rise_stb;
  logic          fall_stb;

  assign cmd_ready = (state_q == IDLE) || (state_q == DONE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;
  assign tck_en    = (state_q == HDR) || (state_q == SHIFT) || (state_q == POST);

  jtag_host_tckgen #(
    .DIV (DIV)
  ) u_tckgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .tck      (jtag_tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Next-state logic: phases advance on TCK falling edges, TDO captured on rising edges,
  // then TMS/TDI for the upcoming period are derived from the next state
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    finish  = 1'b0;
    hdr_pat = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (cmd_valid) begin
          type_d = cmd_type;
          len_d  = decode_len(cmd_len);
          sh_d   = cmd_data;
          cap_d  = '0;
          idx_d  = '0;
          if (cmd_type == CMD_NOP) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (fall_stb) begin
          if (idx_q == hdr_last(type_q)) begin
            idx_d = '0;
            if (type_q == CMD_RST) begin
              state_d = DONE;
              finish  = 1'b1;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      SHIFT: begin
        if (rise_stb) begin
          cap_d[idx_q[4:0]] = jtag_tdo;
        end
        if (fall_stb) begin
          sh_d = sh_q >> 1;
          if (idx_q == len_q - 6'd1) begin
            state_d = POST;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      POST: begin
        if (fall_stb) begin
          if (idx_q == POST_LEN - 6'd1) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      rsp_d = cap_d;
    end

    case (state_d)
      HDR: begin
        hdr_pat = hdr_tms(type_d);
        tms_d   = hdr_pat[idx_d[2:0]];
        tdi_d   = 1'b0;
      end
      SHIFT: begin
        tms_d = (idx_d == len_d - 6'd1);
        tdi_d = sh_d[0];
      end
      POST: begin
        tms_d = POST_TMS[idx_d[0]];
        tdi_d = 1'b0;
      end
      DONE: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
      end
      default: begin
        tms_d = tms_q;
        tdi_d = tdi_q;
      end
    endcase
  end

  // State and datapath registers; TMS idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= CMD_RST;
      len_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

endmodule

// File: doc/jtag_host_drv.md
Name: jtag_host_drv

Overview:
- Synchronous JTAG host (initiator) that drives the MCU debug port `mcu_TCK`/`mcu_TMS`/`mcu_TDI` and samples `mcu_TDO`. It is the opposite end of the TAP inside the system.
- Lets FPGA-side logic or a simulation bench issue TAP reset, IR scan and DR scan commands without a bit-banged model.
- Generates TCK by dividing the system clock, walks the TAP state machine with fixed TMS sequences, and returns the captured TDO bits.

Parameters:
- DIV, 4, TCK half-period in clk cycles (legal ≥1); TCK period = 2*DIV clk.
- DW, 32, maximum scan length and data width.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_type  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=reserved (treated as no-op).
- cmd_len  in  5  scan length in bits; 0 means 32.
- cmd_data  in  DW  TDI data, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse; command complete.
- rsp_data  out  DW  captured TDO bits, LSB = first captured; bits ≥ len are 0; held until next rsp_valid.
- jtag_tck  out  1  to mcu_TCK.
- jtag_tms  out  1  to mcu_TMS.
- jtag_tdi  out  1  to mcu_TDI.
- jtag_tdo  in  1  from mcu_TDO; bench/board supplies it synchronous to TCK.

Behaviour:
- Reset values:
  - jtag_tck=0, jtag_tms=1, jtag_tdi=0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
  - State IDLE, divider counter 0.
  - Reset is asynchronous at any time, including mid-scan. The target TAP state is then undefined, so software issues a TAP reset command first.
- Handshake:
  - A command is accepted on the clk edge where cmd_valid && cmd_ready.
  - cmd_ready falls the next cycle.
  - cmd_type/len/data are latched at acceptance; later changes are ignored.
- TCK generation:
  - Idle: TCK held low; no free-running clock.
  - Each TCK period is a low phase of DIV clk cycles followed by a high phase of DIV clk cycles.
- Signal timing:
  - TMS/TDI for bit k are driven at the start of low phase k. Bit 0 is driven in the cycle after acceptance.
  - TDO is sampled on the clk edge that raises TCK, and only during Shift-xR bits.
- States and TMS sequences (N = number of TCK periods):
  - RST: TMS 1,1,1,1,1,0 (ends in Run-Test/Idle); N=6; TDI=0; rsp_data=0.
  - IR (from RTI): HDR 1,1,0,0 → SHIFT len bits (TMS 0, last bit 1 → Exit1) → POST 1,0 → RTI. N=len+6.
  - DR (from RTI): HDR 1,0,0 → SHIFT len bits (TMS 0, last bit 1) → POST 1,0. N=len+5.
  - TDI=cmd_data[k] in SHIFT; TDI=0 in HDR and POST.
  - Reserved type: N=0; rsp_valid in the cycle after acceptance.
- Completion:
  - After the falling edge ending period N-1, TCK is low and TMS=0.
  - rsp_valid pulses exactly 2*DIV*N clk cycles after the first low-phase cycle of period 0.
  - cmd_ready rises in the same cycle as rsp_valid.
  - A command accepted in that cycle (cmd_valid held) begins immediately, so back-to-back commands have no idle TCK gap.
- Capture: tdo at shift bit k is stored to rsp_data[k] via an internal capture register. rsp_data updates only when rsp_valid fires.
- Counters: the bit counter is 6 bits wide. len=0 decodes to 32, so 32 is the maximum.

Decomposition:
- Package jtag_host_pkg holds:
  - cmd_type encodings.
  - State enum (IDLE, HDR, SHIFT, POST, DONE).
  - Header/post TMS patterns and lengths (IR_HDR=4'b0011 LSB-first, DR_HDR=3'b001, POST=2'b01, RST=6'b011111).
- Sub-module jtag_host_tckgen:
  - Divider counter that produces jtag_tck plus one-cycle rise_stb and fall_stb.
  - Enabled only while busy.
- The top level holds the FSM, shift register and capture register.

Test Plan:
- DIV=2, cmd RST → 6 TCK pulses; TMS sampled at rising edges = 1,1,1,1,1,0; rsp_valid at 24 clk; rsp_data=0; tck low and tms=0 after.
- DR scan, len=0 (=32), data=0, bench TAP model returning IDCODE 0x1E200A6D → 37 TCK pulses; rsp_data=0x1E200A6D; TAP model ends in RTI.
- IR scan len=5, data=0x01 → TDI in Shift-IR = 1,0,0,0,0; model IR=0x01; TAP model passes Select-DR/Select-IR/Capture-IR/Shift-IR/Exit1/Update/RTI; rsp_data = model's IR capture value 0x01 (bits 5..31 zero).
- Back-to-back: cmd_valid held high for IR then DR → second accepted in the cycle rsp_valid fires; no idle TCK period between them; both rsp_data correct.
- Reset mid-SHIFT (rst_n low at bit 10 of a 32-bit DR scan) → same cycle: tck=0, tms=1, cmd_ready=1, rsp_valid=0; after release, RST then DR scan returns 0x1E200A6D.
- cmd_type=3 → no TCK edges; rsp_valid in the cycle after acceptance; rsp_data=0.
